// File: rtl/req_arbiter_4ch.sv
`default_nettype none
// ============================================================================
// req_arbiter_4ch : 4-client fixed/round-robin arbiter with tenure limit
// Revision 1.0
// ============================================================================
module req_arbiter_4ch #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       mode_rr_i,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_id_o,
  output logic       grant_valid_o,
  output logic       preempt_o
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  localparam logic             c_LIMIT_ON  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_id_q, last_id_d;

  logic [1:0] fixed_id;
  logic [1:0] rr_id;
  logic [1:0] rr_idx;
  logic       rr_found;
  logic [1:0] winner;
  logic       owner_req;
  logic       other_req;
  logic       timeout;

  // Fixed priority: the highest set index wins, so later iterations override.
  always_comb begin
    fixed_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req_i[i]) begin
        fixed_id = 2'(i);
      end
    end
  end

  // Round-robin: scan upward from the slot after the previous owner.
  always_comb begin
    rr_id    = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_id_q + 2'(k);
      if (!rr_found && req_i[rr_idx]) begin
        rr_id    = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign winner    = mode_rr_i ? rr_id : fixed_id;
  assign owner_req = req_i[grant_id_q];
  assign other_req = |(req_i & ~grant_q);
  assign timeout   = c_LIMIT_ON && (cnt_q == c_HOLD_LAST) && other_req;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;
    cnt_d         = cnt_q;
    last_id_d     = last_id_q;

    case (state_q)
      c_IDLE: begin
        if (en_i && (|req_i)) begin
          state_d       = c_GRANT;
          grant_d       = 4'b0001 << winner;
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          cnt_d         = '0;
          last_id_d     = winner;
        end
      end

      c_GRANT: begin
        // Release and disable take precedence over a coincident timeout.
        if (!en_i || !owner_req || timeout) begin
          state_d       = c_IDLE;
          grant_d       = 4'b0000;
          grant_id_d    = 2'd0;
          grant_valid_d = 1'b0;
          cnt_d         = '0;
          preempt_d     = en_i && owner_req && timeout;
        end else if (cnt_q != c_CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d       = c_IDLE;
        grant_d       = 4'b0000;
        grant_id_d    = 2'd0;
        grant_valid_d = 1'b0;
        cnt_d         = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_IDLE;
      grant_q       <= 4'b0000;
      grant_id_q    <= 2'd0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
      cnt_q         <= '0;
      last_id_q     <= 2'b11;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
      cnt_q         <= cnt_d;
      last_id_q     <= last_id_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = grant_id_q;
  assign grant_valid_o = grant_valid_q;
  assign preempt_o     = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter_4ch.sv
`default_nettype none
// ============================================================================
// tb_req_arbiter_4ch : self-checking bench for req_arbiter_4ch
// Revision 1.0
// ============================================================================
module tb_req_arbiter_4ch;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       mode_rr = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       preempt;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference state: current owner (-1 when idle), cycles held, previous owner.
  int m_owner = -1;
  int m_ten   = 0;
  int m_last  = 3;
  bit m_pre   = 1'b0;

  req_arbiter_4ch #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .mode_rr_i     (mode_rr),
    .req_i         (req),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid),
    .preempt_o     (preempt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input logic rr, input int last);
    int res;
    bit found;
    res = 0;
    found = 1'b0;
    if (!rr) begin
      for (int i = 0; i < 4; i++) if (r[i]) res = i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(last + k) % 4]) begin
          res = (last + k) % 4;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ten   <= 0;
      m_last  <= 3;
      m_pre   <= 1'b0;
    end else if (m_owner < 0) begin
      m_pre <= 1'b0;
      if (en && (req != 4'b0000)) begin
        m_owner <= pick(req, mode_rr, m_last);
        m_last  <= pick(req, mode_rr, m_last);
        m_ten   <= 1;
      end
    end else if (!en || !req[m_owner]) begin
      m_owner <= -1;
      m_pre   <= 1'b0;
    end else if (MAX_HOLD != 0 && m_ten == MAX_HOLD && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
      m_owner <= -1;
      m_pre   <= 1'b1;
    end else begin
      m_ten <= m_ten + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_grant", grant, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
      check("model_id", {2'b00, grant_id}, (m_owner < 0) ? 4'd0 : 4'(m_owner));
      check("model_valid", {3'b000, grant_valid}, {3'b000, (m_owner >= 0)});
      check("model_preempt", {3'b000, preempt}, {3'b000, m_pre});
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 check("rst_grant", grant, 4'b0000);
    check("rst_id", {2'b00, grant_id}, 4'd0);
    check("rst_valid", {3'b000, grant_valid}, 4'd0);
    check("rst_preempt", {3'b000, preempt}, 4'd0);
    #19 rst_n = 1'b1;
    chk_on = 1'b1;

    // Fixed priority pick, release, then the next requester after the idle gap.
    @(negedge clk);
    mode_rr = 1'b0; en = 1'b1; req = 4'b0110;
    @(negedge clk);
    check("s1_grant", grant, 4'b0100);
    check("s1_id", {2'b00, grant_id}, 4'd2);
    check("s1_valid", {3'b000, grant_valid}, 4'd1);
    req = 4'b0010;
    @(negedge clk);
    check("s1_release", grant, 4'b0000);
    @(negedge clk);
    check("s1_next", grant, 4'b0010);
    check("s1_next_id", {2'b00, grant_id}, 4'd1);
    req = 4'b0000;
    @(negedge clk);

    // Tenure limit in fixed mode: ch3 holds 8 cycles, is preempted, wins again.
    req = 4'b1000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("fx_hold", grant, 4'b1000);
      if (c == 2) req = 4'b1010;
    end
    @(negedge clk);
    check("fx_cleared", grant, 4'b0000);
    check("fx_preempt", {3'b000, preempt}, 4'd1);
    @(negedge clk);
    check("fx_rewin", grant, 4'b1000);
    check("fx_pre_low", {3'b000, preempt}, 4'd0);

    // Same in round-robin mode: ch1 takes over after the preemption.
    req = 4'b0000;
    @(negedge clk);
    mode_rr = 1'b1; req = 4'b1000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("rr_hold", grant, 4'b1000);
      if (c == 2) req = 4'b1010;
    end
    @(negedge clk);
    check("rr_preempt", {3'b000, preempt}, 4'd1);
    @(negedge clk);
    check("rr_next", grant, 4'b0010);

    // Lone requester never gets preempted.
    req = 4'b0000;
    @(negedge clk);
    mode_rr = 1'b0; req = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      check("solo_grant", grant, 4'b0001);
      check("solo_preempt", {3'b000, preempt}, 4'd0);
      @(negedge clk);
    end

    // Disable mid-grant clears outputs and blocks new grants.
    en = 1'b0; req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("dis_grant", grant, 4'b0000);
      check("dis_preempt", {3'b000, preempt}, 4'd0);
    end

    // Asynchronous reset mid-grant, then RR restarts at ch0 and rotates.
    en = 1'b1; mode_rr = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", {3'b000, grant_valid}, 4'd1);
    #2 rst_n = 1'b0;
    #1 check("arst_grant", grant, 4'b0000);
    check("arst_id", {2'b00, grant_id}, 4'd0);
    check("arst_valid", {3'b000, grant_valid}, 4'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rr_first", grant, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = 4'b1111 & ~(4'b0001 << k);
      @(negedge clk);
      check("rot_gap", grant, 4'b0000);
      req = 4'b1111;
      @(negedge clk);
      check("rot_next", grant, 4'b0001 << ((k + 1) % 4));
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      en = ($urandom_range(19) != 0);
      if ($urandom_range(31) == 0) mode_rr = ~mode_rr;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(9) == 0) req[b] = ~req[b];
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
